// File: rtl/pio_in_pkg.sv
// Shared definitions for the multi-channel input PIO: register offsets,
// edge-detect mode encodings and a constant clog2 helper.
package pio_in_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Ceiling log2; clog2(1) = 0 so a single channel needs no select bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pio_in_sync_edge.sv
// One input channel: optional multi-stage synchroniser, previous-value
// register and per-bit edge detector (rising, falling or any change).
module pio_in_sync_edge
  import pio_in_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sync,
  output logic [DATA_W-1:0] det
);

  logic [DATA_W-1:0] prev;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync = din;
  end else begin : g_sync
    localparam int SW = SYNC_STAGES * DATA_W;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] stg;

    // Shift the word through the synchroniser chain; stage 0 samples din
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stg <= '0;
      else          stg <= SW'({stg, din});
    end

    assign sync = stg[SYNC_STAGES-1];
  end

  // Previous value starts at 0 alongside the synchroniser, so no stale edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= sync;
  end

  // Per-bit edge detect selected by EDGE_MODE
  always_comb begin
    det = sync & ~prev;
    if (EDGE_MODE == EDGE_FALL)     det = ~sync & prev;
    else if (EDGE_MODE == EDGE_ANY) det = sync ^ prev;
  end

endmodule

// File: rtl/pio_in_multi_capture.sv
// Multi-channel Avalon-MM input PIO with per-channel synchronisation,
// sticky edge capture (write-1-to-clear), interrupt mask and registered IRQ.
// Optional macro PIO_IN_SNAPSHOT_EN adds a coherent snapshot bank: a write
// to channel 0 STAT latches all channels, and DATA then reads the snapshot.
module pio_in_multi_capture
  import pio_in_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [clog2(N_CH)+1:0]   address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [DATA_W-1:0]        writedata,
  input  logic [N_CH*DATA_W-1:0]   in_port,
  output logic [DATA_W-1:0]        readdata,
  output logic                     irq
);

  localparam int SEL_W = 5;

  logic [SEL_W-1:0]  ch_sel;
  logic [1:0]        reg_sel;
  logic              wr_en;
  logic [DATA_W-1:0] sync_a [N_CH];
  logic [DATA_W-1:0] data_a [N_CH];
  logic [DATA_W-1:0] mask_a [N_CH];
  logic [DATA_W-1:0] edge_a [N_CH];
  logic [DATA_W-1:0] stat_a [N_CH];
  logic [DATA_W-1:0] rd_next;
  logic              irq_next;

  assign reg_sel = address[1:0];
  assign ch_sel  = SEL_W'(address >> 2);
  assign wr_en   = chipselect & ~write_n;

`ifdef PIO_IN_SNAPSHOT_EN
  logic [DATA_W-1:0] snap_q [N_CH];
  logic [7:0]        snap_cnt;
  logic              snap_take;

  assign snap_take = wr_en && (ch_sel == '0) && (reg_sel == REG_STAT);

  // Latch every channel together so multi-word values read back coherently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) snap_q[c] <= '0;
      snap_cnt <= '0;
    end else if (snap_take) begin
      for (int c = 0; c < N_CH; c++) snap_q[c] <= sync_a[c];
      snap_cnt <= snap_cnt + 8'd1;
    end
  end
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_W-1:0] det;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] edge_q;
    logic [DATA_W-1:0] clr;
    logic              hit_ch;

    pio_in_sync_edge #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[c*DATA_W +: DATA_W]),
      .sync    (sync_a[c]),
      .det     (det)
    );

    assign hit_ch = wr_en && (ch_sel == SEL_W'(c));
    assign clr    = (hit_ch && (reg_sel == REG_EDGE)) ? writedata : '0;

    // MASK is plain RW; EDGE is sticky with W1C, and a new edge beats a clear
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mask_q <= '0;
        edge_q <= '0;
      end else begin
        if (hit_ch && (reg_sel == REG_MASK)) mask_q <= writedata;
        edge_q <= (edge_q & ~clr) | det;
      end
    end

    assign mask_a[c] = mask_q;
    assign edge_a[c] = edge_q;

`ifdef PIO_IN_SNAPSHOT_EN
    assign data_a[c] = snap_q[c];
    assign stat_a[c] = (c == 0) ? DATA_W'(snap_cnt) : '0;
`else
    assign data_a[c] = sync_a[c];
    assign stat_a[c] = '0;
`endif
  end

  // Read mux; unmapped channel indices fall through to zero
  always_comb begin
    rd_next = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == SEL_W'(c)) begin
        case (reg_sel)
          REG_DATA: rd_next = data_a[c];
          REG_MASK: rd_next = mask_a[c];
          REG_EDGE: rd_next = edge_a[c];
          default:  rd_next = stat_a[c];
        endcase
      end
    end
  end

  // Interrupt is any unmasked captured edge on any channel
  always_comb begin
    irq_next = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      irq_next = irq_next | (|(edge_a[c] & mask_a[c]));
    end
  end

  // Registered read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= irq_next;
    end
  end

endmodule

// File: tb/tb_pio_in_multi_capture.sv
// Directed self-checking bench for pio_in_multi_capture (N_CH=3, two-stage
// synchroniser, rising-edge capture). Snapshot checks run when
// PIO_IN_SNAPSHOT_EN is defined.
module tb_pio_in_multi_capture;

  localparam int DATA_W = 32;
  localparam int N_CH   = 3;
  localparam int SYNC   = 2;

  logic                   clk;
  logic                   reset_n;
  logic [3:0]             address;
  logic                   chipselect;
  logic                   write_n;
  logic [DATA_W-1:0]      writedata;
  logic [N_CH*DATA_W-1:0] in_port;
  logic [DATA_W-1:0]      readdata;
  logic                   irq;

  int checks = 0;
  int errors = 0;
  int snap_cnt = 0;

  pio_in_multi_capture #(
    .DATA_W      (DATA_W),
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC),
    .EDGE_MODE   (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    address = a;
    @(posedge clk);
    #1;
    v = readdata;
  endtask

  task automatic refresh();
`ifdef PIO_IN_SNAPSHOT_EN
    wr(4'b0011, 32'h0);
    snap_cnt++;
`endif
  endtask

  logic [31:0] v;

  initial begin
    tbl[0]  = '{1'b1, 4'b0101, 32'hA5A5_0F0F, "wr_mask_ch1"};
    tbl[1]  = '{1'b0, 4'b0101, 32'hA5A5_0F0F, "mask_ch1"};
    tbl[2]  = '{1'b0, 4'b0100, 32'h1234_5678, "data_ch1"};
    tbl[3]  = '{1'b0, 4'b1000, 32'h8000_0000, "data_ch2"};
    tbl[4]  = '{1'b0, 4'b1100, 32'h0000_0000, "data_ch3_oor"};
    tbl[5]  = '{1'b1, 4'b1101, 32'hFFFF_FFFF, "wr_mask_ch3"};
    tbl[6]  = '{1'b0, 4'b1101, 32'h0000_0000, "mask_ch3_oor"};
    tbl[7]  = '{1'b1, 4'b0000, 32'hFFFF_FFFF, "wr_data_ch0"};
    tbl[8]  = '{1'b0, 4'b0000, 32'h0000_00C3, "data_ch0_after_wr"};
    tbl[9]  = '{1'b0, 4'b0001, 32'h0000_0000, "mask_ch0_after_wr"};
    tbl[10] = '{1'b0, 4'b0010, 32'h0000_0000, "edge_ch0_after_wr"};
    tbl[11] = '{1'b1, 4'b0101, 32'h0000_0000, "wr_mask_ch1_zero"};
    tbl[12] = '{1'b0, 4'b0101, 32'h0000_0000, "mask_ch1_zero"};
    tbl[13] = '{1'b0, 4'b0110, 32'h0000_0000, "edge_ch1_clean"};

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 4'b0000;
    writedata  = '0;
    in_port    = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Build up live state, then pull reset mid-cycle
    in_port = {3{32'hFFFF_FFFF}};
    wr(4'b0001, 32'hFFFF_FFFF);
    tick(5);
    address = 4'b0001;
    tick(1);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    check("pre_reset_rdata", readdata, 32'hFFFF_FFFF);
    #2 reset_n = 1'b0;
    #1;
    check("reset_rdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    in_port = {32'h0, 32'h1234_5678, 32'h0};
    address = 4'b0100;
    tick(2);
    reset_n = 1'b1;
`ifndef PIO_IN_SNAPSHOT_EN
    tick(SYNC);
    check("data_latency_early", readdata, 32'h0);
    tick(1);
    check("data_latency", readdata, 32'h1234_5678);
`else
    tick(SYNC + 1);
    refresh();
    rd(4'b0100, v);
    check("data_after_reset", v, 32'h1234_5678);
`endif
    check("irq_after_reset", {31'd0, irq}, 32'd0);

    // Settle known inputs and clear any captured edges
    in_port = {32'h8000_0000, 32'h1234_5678, 32'h0000_00C3};
    tick(4);
    wr(4'b0010, 32'hFFFF_FFFF);
    wr(4'b0110, 32'hFFFF_FFFF);
    wr(4'b1010, 32'hFFFF_FFFF);
    refresh();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].data);
      end else begin
        rd(tbl[i].addr, v);
        check(tbl[i].name, v, tbl[i].data);
      end
    end
    check("irq_after_table", {31'd0, irq}, 32'd0);

    // Rising edge on ch2 bit0 with mask set
    wr(4'b1001, 32'h1);
    in_port[2*DATA_W +: DATA_W] = 32'h8000_0001;
    address = 4'b1010;
    tick(SYNC + 1);
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    tick(2);
    check("irq_rise", {31'd0, irq}, 32'd1);
    check("edge_ch2_rise", readdata, 32'h1);
    wr(4'b1010, 32'h1);
    check("irq_hold_on_clear", {31'd0, irq}, 32'd1);
    tick(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Masked edge on ch0 bit5, then unmask
    in_port[0 +: DATA_W] = 32'h0000_00E3;
    tick(SYNC + 3);
    check("irq_masked", {31'd0, irq}, 32'd0);
    rd(4'b0010, v);
    check("edge_ch0_masked", v, 32'h20);
    wr(4'b0001, 32'h20);
    check("irq_unmask_same", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq_unmask", {31'd0, irq}, 32'd1);
    wr(4'b0010, 32'h20);
    wr(4'b0001, 32'h0);
    tick(2);
    check("irq_idle", {31'd0, irq}, 32'd0);

    // Set/clear collision on ch2 bit0
    in_port[2*DATA_W +: DATA_W] = 32'h8000_0000;
    tick(4);
    in_port[2*DATA_W +: DATA_W] = 32'h8000_0001;
    tick(SYNC);
    wr(4'b1010, 32'h1);
    rd(4'b1010, v);
    check("edge_collision", v, 32'h1);
    wr(4'b1010, 32'h1);
    rd(4'b1010, v);
    check("edge_w1c", v, 32'h0);

`ifndef PIO_IN_SNAPSHOT_EN
    wr(4'b0011, 32'hFFFF_FFFF);
    rd(4'b0011, v);
    check("stat_absent", v, 32'h0);
    in_port[0 +: DATA_W] = 32'h0BAD_F00D;
    tick(SYNC + 1);
    rd(4'b0000, v);
    check("data_live", v, 32'h0BAD_F00D);
`else
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    in_port = {32'h0, 32'h0000_5555, 32'hAAAA_0000};
    tick(SYNC + 1);
    wr(4'b0011, 32'h0);
    in_port = {32'h0, 32'h1111_1111, 32'h2222_2222};
    tick(4);
    rd(4'b0000, v);
    check("snap_ch0", v, 32'hAAAA_0000);
    rd(4'b0100, v);
    check("snap_ch1", v, 32'h0000_5555);
    rd(4'b0011, v);
    check("snap_stat_one", v, 32'h1);
    rd(4'b0111, v);
    check("snap_stat_ch1", v, 32'h0);
    repeat (255) wr(4'b0011, 32'h0);
    rd(4'b0011, v);
    check("snap_stat_wrap", v, 32'h0);
    rd(4'b0000, v);
    check("snap_ch0_new", v, 32'h2222_2222);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
